// File: rtl/led_pattern_sequencer_if.sv
// Control and LED-output bundle between board switches/keys and the pattern sequencer.
interface led_pattern_sequencer_if #(
  parameter int NUM_LEDS = 10
);
  logic [1:0]          mode;
  logic [1:0]          speed;
  logic                run;
  logic                step;
  logic [NUM_LEDS-1:0] LEDR;
  logic                tick;
  logic [3:0]          pos;

  modport master (output mode, speed, run, step, input LEDR, tick, pos);
  modport slave  (input mode, speed, run, step, output LEDR, tick, pos);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Steps the board LEDs through scan, fill/drain, blink and off patterns at a
// prescaled rate derived from CLOCK_50, or one step per key press when halted.
module led_pattern_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int NUM_LEDS = 10
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  led_pattern_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    INIT, SCAN_UP, SCAN_DOWN, FILL, DRAIN, BLINK_ON, BLINK_OFF, OFF
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0] LVL_FULL = 5'(NUM_LEDS);
  localparam logic [4:0] LVL_LAST = 5'(NUM_LEDS - 1);
  localparam logic [4:0] LVL_PRE  = 5'(NUM_LEDS - 2);

  state_t              state_q, state_d;
  logic [4:0]          level_q, level_d;
  logic [3:0]          pos_q, pos_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                tick_q, tick_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [2:0]          sub_q, sub_d;
  logic [2:0]          mode_q, mode_d;

  logic       base_tick, step_ev, load;
  logic [2:0] sub_lim;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      level_q <= '0;
      pos_q   <= '0;
      led_q   <= '0;
      tick_q  <= 1'b0;
      presc_q <= '0;
      sub_q   <= '0;
      mode_q  <= 3'b100;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
      sub_q   <= sub_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tick_d  = 1'b0;
    presc_d = presc_q;
    sub_d   = sub_q;
    mode_d  = mode_q;

    base_tick = bus.run && (presc_q == PRESC_LAST);
    sub_lim   = 3'((4'd1 << bus.speed) - 4'd1);
    // >= rather than == so lowering speed mid-count fires on the next base tick
    step_ev   = (base_tick && (sub_q >= sub_lim)) || (!bus.run && bus.step);
    load      = (mode_q != {1'b0, bus.mode});

    if (bus.run) begin
      presc_d = base_tick ? '0 : presc_q + PW'(1);
      if (base_tick) sub_d = (sub_q >= sub_lim) ? '0 : sub_q + 3'd1;
    end

    if (load) begin
      presc_d = '0;
      sub_d   = '0;
      mode_d  = {1'b0, bus.mode};
      level_d = '0;
      tick_d  = 1'b1;
      case (bus.mode)
        2'b00:   state_d = SCAN_UP;
        2'b01:   state_d = FILL;
        2'b10:   state_d = BLINK_ON;
        default: state_d = OFF;
      endcase
    end else if (step_ev && state_q != INIT) begin
      tick_d = 1'b1;
      case (state_q)
        SCAN_UP:
          if (level_q >= LVL_LAST) begin state_d = SCAN_DOWN; level_d = LVL_PRE; end
          else level_d = level_q + 5'd1;
        SCAN_DOWN:
          if (level_q == '0) begin state_d = SCAN_UP; level_d = 5'd1; end
          else level_d = level_q - 5'd1;
        FILL:
          if (level_q >= LVL_FULL) begin state_d = DRAIN; level_d = LVL_LAST; end
          else level_d = level_q + 5'd1;
        DRAIN:
          if (level_q == '0) begin state_d = FILL; level_d = 5'd1; end
          else level_d = level_q - 5'd1;
        BLINK_ON:  begin state_d = BLINK_OFF; level_d = '0; end
        BLINK_OFF: begin state_d = BLINK_ON;  level_d = '0; end
        default:   level_d = '0;
      endcase
    end

    // Full fill level of a 16-LED bar does not fit the 4-bit port; it saturates at 15
    pos_d = (level_d > 5'd15) ? 4'hF : level_d[3:0];

    led_d = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      case (state_d)
        SCAN_UP, SCAN_DOWN: led_d[i] = (level_d == 5'(i));
        FILL, DRAIN:        led_d[i] = (5'(i) < level_d);
        BLINK_ON:           led_d[i] = 1'b1;
        default:            led_d[i] = 1'b0;
      endcase
    end
  end

  assign bus.LEDR = led_q;
  assign bus.tick = tick_q;
  assign bus.pos  = pos_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus queues expected (LEDR, pos, timing) per tick; a
// monitor pops one entry for every tick pulse the sequencer presents.
module tb_led_pattern_sequencer;
  localparam int N = 10;

  typedef struct {
    int led;
    int pos;
    int gap;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  exp_t sb[$];

  led_pattern_sequencer_if #(.NUM_LEDS(N)) bus ();

  led_pattern_sequencer #(.TICK_DIV(4), .NUM_LEDS(N)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int led, input int pos, input int gap, input int at);
    exp_t e;
    e.led = led; e.pos = pos; e.gap = gap; e.at = at;
    sb.push_back(e);
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      nclk();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d ticks outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.tick === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: LEDR=%0h pos=%0d at cyc %0d, expected no tick",
                 bus.LEDR, bus.pos, cyc);
      end else begin
        e = sb.pop_front();
        check("ledr", int'(bus.LEDR), e.led);
        check("pos", int'(bus.pos), e.pos);
        if (e.gap > 0) check("step_gap", cyc - last_cyc, e.gap);
        if (e.at >= 0) check("tick_cycle", cyc, e.at);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    int c0;
    int lc;
    bus.mode  = 2'b00;
    bus.speed = 2'd0;
    bus.run   = 1'b1;
    bus.step  = 1'b0;

    #12;
    check("reset_ledr", int'(bus.LEDR), 0);
    check("reset_pos", int'(bus.pos), 0);
    check("reset_tick", int'(bus.tick), 0);

    // Scan bounce, speed 0: step every 4 cycles
    nclk();
    reset = 1'b0;
    push(1, 0, 0, cyc + 1);
    for (int p = 1; p <= 9; p++) push(1 << p, p, 4, -1);
    for (int p = 8; p >= 0; p--) push(1 << p, p, 4, -1);
    push(2, 1, 4, -1);
    drain(120, "scan");

    // Fill/drain, speed 1: step every 8 cycles
    bus.mode  = 2'b01;
    bus.speed = 2'd1;
    push(0, 0, 0, cyc + 1);
    for (int p = 1; p <= 10; p++) push((1 << p) - 1, p, 8, -1);
    for (int p = 9; p >= 0; p--) push((1 << p) - 1, p, 8, -1);
    push(1, 1, 8, -1);
    drain(220, "fill");

    // Hold at scan pos 3, manual step, then ignored step with run=1
    bus.mode  = 2'b00;
    bus.speed = 2'd0;
    push(1, 0, 0, cyc + 1);
    push(2, 1, 4, -1);
    push(4, 2, 4, -1);
    push(8, 3, 4, -1);
    drain(40, "scan_to_3");
    bus.run = 1'b0;
    repeat (100) nclk();
    check("hold_ledr", int'(bus.LEDR), 8);
    check("hold_pos", int'(bus.pos), 3);
    bus.step = 1'b1;
    push(16, 4, 0, cyc + 1);
    nclk();
    bus.step = 1'b0;
    drain(5, "manual_step");
    bus.run  = 1'b1;
    bus.step = 1'b1;
    c0 = cyc;
    push(32, 5, 0, c0 + 4);
    nclk();
    bus.step = 1'b0;

    // Mode change to BLINK coinciding with a timed step event
    while (cyc < c0 + 7) nclk();
    bus.mode = 2'b10;
    push(10'h3FF, 0, 0, c0 + 8);
    push(0, 0, 0, c0 + 12);
    push(10'h3FF, 0, 0, c0 + 16);
    push(0, 0, 0, c0 + 20);
    drain(40, "blink");

    // Speed 3 -> 0 while the sub-counter sits at 5
    bus.mode  = 2'b00;
    bus.speed = 2'd3;
    lc = cyc + 1;
    push(1, 0, 0, lc);
    while (cyc < lc + 21) nclk();
    bus.speed = 2'd0;
    push(2, 1, 0, lc + 24);
    push(4, 2, 0, lc + 28);
    drain(40, "speed_drop");

    // Reset in the middle of a drain at pos 6
    bus.mode  = 2'b01;
    bus.speed = 2'd1;
    push(0, 0, 0, cyc + 1);
    for (int p = 1; p <= 10; p++) push((1 << p) - 1, p, 8, -1);
    for (int p = 9; p >= 6; p--) push((1 << p) - 1, p, 8, -1);
    drain(200, "drain_to_6");
    check("pre_reset_tick", int'(bus.tick), 1);
    reset = 1'b1;
    #1;
    check("async_reset_ledr", int'(bus.LEDR), 0);
    check("async_reset_pos", int'(bus.pos), 0);
    check("async_reset_tick", int'(bus.tick), 0);
    nclk();
    nclk();
    reset = 1'b0;
    push(0, 0, 0, cyc + 1);
    push(1, 1, 8, -1);
    push(3, 2, 8, -1);
    push(7, 3, 8, -1);
    drain(60, "restart_fill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
